pong_court: RTL and testbench

PONG_COURT -- requirements
Module: pong_court

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_press_latch.sv | 24 ++
 rtl/pong_court.sv | 154 +++++++++++++++
 tb/tb_pong_court.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong court: FSM states, player indices
// and ball direction encoding.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE,
        FLIGHT,
        POINT,
        OVER
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // DIR_UP moves toward the highest LED, i.e. toward player 1.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pong_press_latch.sv
// Rising-edge detector on a debounced button with a sticky flag that the
// game FSM clears once it has consumed the press.
module pong_press_latch (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clear,
    output logic flag
);

    logic prev;

    // A new edge arriving in the same cycle as a clear is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            flag <= 1'b0;
        end else begin
            prev <= btn;
            flag <= (flag & ~clear) | (btn & ~prev);
        end
    end

endmodule

// File: rtl/pong_court.sv
// Two-player LED pong: serve, rally with speed-up on each return, scoring
// and game end. All outputs come straight from registers.
module pong_court #(
    parameter int NUM_LEDS  = 8,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 15,
    parameter int INIT_STEP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                btn0,
    input  logic                btn1,
    output logic [NUM_LEDS-1:0] leds,
    output logic [SCORE_W-1:0]  score0,
    output logic [SCORE_W-1:0]  score1,
    output logic                serving,
    output logic                game_over,
    output logic                winner
);
    import pong_pkg::*;

    localparam int                PW    = $clog2(NUM_LEDS);
    localparam logic [PW-1:0]     LAST  = PW'(NUM_LEDS - 1);
    localparam logic [3:0]        STEP0 = 4'(INIT_STEP);
    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);

    state_t              state, state_n;
    dir_t                dir, dir_n;
    logic [PW-1:0]       pos, pos_n;
    logic [3:0]          step_len, step_len_n, step_cnt, step_cnt_n;
    logic [SCORE_W-1:0]  score0_n, score1_n;
    logic                serving_n, winner_n, game_over_n;
    logic                flag0, flag1, clr0, clr1;
    logic                receiver, rflag, at_end, move, point, scorer;

    function automatic logic [PW-1:0] end_of(input logic p);
        return p ? LAST : '0;
    endfunction

    pong_press_latch u_latch0 (.clk(clk), .reset(reset), .btn(btn0), .clear(clr0), .flag(flag0));
    pong_press_latch u_latch1 (.clk(clk), .reset(reset), .btn(btn1), .clear(clr1), .flag(flag1));

    always_comb begin
        state_n     = state;
        dir_n       = dir;
        pos_n       = pos;
        step_len_n  = step_len;
        step_cnt_n  = step_cnt;
        score0_n    = score0;
        score1_n    = score1;
        serving_n   = serving;
        winner_n    = winner;
        game_over_n = game_over;
        clr0        = 1'b0;
        clr1        = 1'b0;
        point       = 1'b0;
        scorer      = P0;
        receiver    = (dir == DIR_UP) ? P1 : P0;
        rflag       = receiver ? flag1 : flag0;
        at_end      = (pos == end_of(receiver));
        move        = (step_cnt == 4'd1);

        case (state)
            SERVE: begin
                if (tick) begin
                    clr0 = 1'b1;
                    clr1 = 1'b1;
                    if (serving ? flag1 : flag0) begin
                        state_n    = FLIGHT;
                        dir_n      = (serving == P0) ? DIR_UP : DIR_DOWN;
                        step_cnt_n = step_len;
                    end
                end
            end
            FLIGHT: begin
                if (tick) begin
                    // Sender presses are never meaningful in flight; drop them.
                    if (receiver == P1) clr0 = 1'b1;
                    else                clr1 = 1'b1;
                    if (rflag && !at_end) begin
                        point  = 1'b1;
                        scorer = ~receiver;
                    end else if (move) begin
                        if (at_end && rflag) begin
                            if (receiver == P1) clr1 = 1'b1;
                            else                clr0 = 1'b1;
                            dir_n      = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                            pos_n      = receiver ? pos - 1'b1 : pos + 1'b1;
                            step_len_n = (step_len > 4'd1) ? step_len - 4'd1 : 4'd1;
                            step_cnt_n = step_len_n;
                        end else if (at_end) begin
                            point  = 1'b1;
                            scorer = ~receiver;
                        end else begin
                            pos_n      = (dir == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
                            step_cnt_n = step_len;
                        end
                    end else begin
                        // A return press at the end is held until the move tick.
                        step_cnt_n = step_cnt - 4'd1;
                    end
                end
            end
            POINT: begin
                clr0    = 1'b1;
                clr1    = 1'b1;
                state_n = game_over ? OVER : SERVE;
            end
            default: ;
        endcase

        // Score and reposition on entry to POINT so POINT already shows the result.
        if (point) begin
            state_n    = POINT;
            winner_n   = scorer;
            serving_n  = ~serving;
            step_len_n = STEP0;
            if (scorer == P1) score1_n = score1 + SCORE_W'(score1 != WIN);
            else              score0_n = score0 + SCORE_W'(score0 != WIN);
            game_over_n = (score0_n == WIN) || (score1_n == WIN);
            pos_n       = game_over_n ? end_of(scorer) : end_of(~serving);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SERVE;
            dir       <= DIR_UP;
            pos       <= '0;
            step_len  <= STEP0;
            step_cnt  <= STEP0;
            score0    <= '0;
            score1    <= '0;
            serving   <= P0;
            winner    <= P0;
            game_over <= 1'b0;
            leds      <= NUM_LEDS'(1);
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            pos       <= pos_n;
            step_len  <= step_len_n;
            step_cnt  <= step_cnt_n;
            score0    <= score0_n;
            score1    <= score1_n;
            serving   <= serving_n;
            winner    <= winner_n;
            game_over <= game_over_n;
            leds      <= NUM_LEDS'(1) << pos_n;
        end
    end

endmodule

// File: tb/tb_pong_court.sv
// Directed bench for pong_court: a fast-ball, short-game instance and a
// default-speed instance sharing clock, reset and buttons.
module tb_pong_court;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick1 = 1'b0;
    logic       tick4 = 1'b0;
    logic       btn0 = 1'b0;
    logic       btn1 = 1'b0;

    logic [7:0] leds1, leds4;
    logic [3:0] s0_1, s1_1, s0_4, s1_4;
    logic       serving1, serving4, over1, over4, winner1, winner4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pong_court #(.NUM_LEDS(8), .SCORE_W(4), .WIN_SCORE(3), .INIT_STEP(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick1), .btn0(btn0), .btn1(btn1),
        .leds(leds1), .score0(s0_1), .score1(s1_1), .serving(serving1),
        .game_over(over1), .winner(winner1)
    );

    pong_court #(.NUM_LEDS(8), .SCORE_W(4), .WIN_SCORE(15), .INIT_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .tick(tick4), .btn0(btn0), .btn1(btn1),
        .leds(leds4), .score0(s0_4), .score1(s1_4), .serving(serving4),
        .game_over(over4), .winner(winner4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic t1, input logic t4, input logic b0, input logic b1);
        @(negedge clk);
        reset = 1'b0;
        tick1 = t1;
        tick4 = t4;
        btn0  = b0;
        btn1  = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic t1, input logic t4);
        @(negedge clk);
        reset = 1'b1;
        tick1 = t1;
        tick4 = t4;
        btn0  = 1'b0;
        btn1  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic press(input logic b0, input logic b1);
        cyc(1'b0, 1'b0, b0, b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run4_to(input logic [7:0] target, input string tag);
        int n;
        n = 0;
        while (leds4 !== target && n < 200) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk(tag, leds4, target);
    endtask

    task automatic count_move4(output int n);
        logic [7:0] prev;
        prev = leds4;
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end while (leds4 === prev && n < 40);
    endtask

    int         iv;
    int         ret_iv [5] = '{4, 3, 2, 1, 1};
    logic [7:0] ret_pos[5] = '{8'h40, 8'h02, 8'h40, 8'h02, 8'h40};

    initial begin
        // Reset with tick high
        do_reset(1'b1, 1'b1);
        chk("rst_leds", leds1, 8'h01);
        chk("rst_s0", s0_1, 0);
        chk("rst_s1", s1_1, 0);
        chk("rst_serving", serving1, 0);
        chk("rst_over", over1, 0);
        chk("rst_winner", winner1, 0);

        // Serve with no return: ball walks 0..7, then point to player 0
        press(1'b1, 1'b0);
        ticks1(1);
        chk("serve_hold", leds1, 8'h01);
        for (int k = 1; k <= 7; k++) begin
            ticks1(1);
            chk("walk", leds1, 32'(1 << k));
        end
        ticks1(1);
        chk("noret_s0", s0_1, 1);
        chk("noret_serving", serving1, 1);
        chk("noret_leds", leds1, 8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Player 1 serves; player 0 presses early at bit 3
        press(1'b0, 1'b1);
        ticks1(5);
        chk("p1serve_pos3", leds1, 8'h08);
        press(1'b1, 1'b0);
        ticks1(1);
        chk("fault0_s1", s1_1, 1);
        chk("fault0_leds", leds1, 8'h01);
        chk("fault0_serving", serving1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Player 0 serves; player 1 presses early at bit 3 heading right
        press(1'b1, 1'b0);
        ticks1(4);
        chk("p0serve_pos3", leds1, 8'h08);
        press(1'b0, 1'b1);
        ticks1(1);
        chk("fault1_s0", s0_1, 2);
        chk("fault1_leds", leds1, 8'h80);
        chk("fault1_serving", serving1, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous presses at both ends: return wins, sender press dropped
        press(1'b0, 1'b1);
        ticks1(8);
        chk("at_bit0", leds1, 8'h01);
        press(1'b1, 1'b1);
        ticks1(1);
        chk("sim0_ret", leds1, 8'h02);
        ticks1(1);
        chk("sim0_next", leds1, 8'h04);
        chk("sim0_s1", s1_1, 1);
        ticks1(5);
        chk("at_bit7", leds1, 8'h80);
        press(1'b1, 1'b1);
        ticks1(1);
        chk("sim7_ret", leds1, 8'h40);
        ticks1(1);
        chk("sim7_next", leds1, 8'h20);
        chk("sim7_s0", s0_1, 2);
        ticks1(6);
        chk("miss0_s1", s1_1, 2);
        chk("miss0_serving", serving1, 0);
        chk("miss0_leds", leds1, 8'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Player 1 takes the third point: game over
        press(1'b1, 1'b0);
        ticks1(8);
        press(1'b0, 1'b1);
        ticks1(1);
        chk("ret7", leds1, 8'h40);
        press(1'b1, 1'b0);
        ticks1(1);
        chk("end_s1", s1_1, 3);
        chk("end_over", over1, 1);
        chk("end_winner", winner1, 1);
        chk("end_leds", leds1, 8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        ticks1(2);
        press(1'b0, 1'b1);
        ticks1(3);
        chk("frozen_s0", s0_1, 2);
        chk("frozen_s1", s1_1, 3);
        chk("frozen_leds", leds1, 8'h80);
        chk("frozen_over", over1, 1);
        chk("frozen_winner", winner1, 1);

        // Reset out of OVER with tick high
        do_reset(1'b1, 1'b1);
        chk("rst2_leds", leds1, 8'h01);
        chk("rst2_s1", s1_1, 0);
        chk("rst2_over", over1, 0);
        chk("rst2_winner", winner1, 0);
        chk("rst2_serving", serving1, 0);

        // Speed-up across five returns at INIT_STEP=4
        press(1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        count_move4(iv);
        chk("iv_serve", iv, 4);
        run4_to(8'h80, "reach7");
        for (int k = 0; k < 5; k++) begin
            press(k % 2 == 1, k % 2 == 0);
            count_move4(iv);
            chk("iv_return", iv, ret_iv[k]);
            chk("ret_pos", leds4, ret_pos[k]);
            run4_to((k % 2 == 0) ? 8'h01 : 8'h80, "reach_end");
        end
        count_move4(iv);
        chk("miss_iv", iv, 1);
        chk("miss_s1", s1_4, 1);
        chk("miss_serving", serving4, 1);
        chk("miss_leds", leds4, 8'h80);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        count_move4(iv);
        chk("iv_restored", iv, 4);

        // Reset mid-rally with tick high
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        chk("rst3_leds", leds4, 8'h01);
        chk("rst3_s1", s1_4, 0);
        chk("rst3_serving", serving4, 0);
        chk("rst3_over", over4, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst3_hold", leds4, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
